// File: rtl/spram_rsp_fifo.sv
// Two-entry response FIFO between the RAM read port and the response stream.
// Latency: a push is visible on out_valid the cycle after it is written.
// Backpressure: holds out_data stable while out_valid && !out_ready; the caller's credit check prevents overflow.
module spram_rsp_fifo #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage needs no reset: contents are only observable once count says so.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assert property (@(posedge clk) disable iff (!rst_n) push |-> (count != 2'd2));

endmodule

// File: rtl/spram_access_ctrl.sv
// Arbitrates a write and a read command stream onto one single-port RAM port.
// Latency: read granted in cycle N returns rsp_valid in N+2 at the earliest.
// Backpressure: at most 2 reads outstanding (FIFO + in flight); writes proceed regardless.
module spram_access_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int RAM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

    logic       last_grant;
    logic       inflight;
    logic [1:0] occ;
    logic       rsp_pop;
    logic [2:0] credit_used;
    logic       rd_eligible;
    logic       wr_gnt;
    logic       rd_gnt;

    // Counting the same-cycle pop lets a full-rate read stream run with rsp_ready high.
    assign rsp_pop     = rsp_valid && rsp_ready;
    assign credit_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, rsp_pop};
    assign rd_eligible = rd_valid && (credit_used < 3'd2);

    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (rst_n) begin
            if (wr_valid && rd_eligible) begin
                if (last_grant == GRANT_RD) wr_gnt = 1'b1;
                else                        rd_gnt = 1'b1;
            end else begin
                wr_gnt = wr_valid;
                rd_gnt = rd_eligible;
            end
        end
    end

    assign wr_ready = wr_gnt;
    assign rd_ready = rd_gnt;
    assign ram_we   = wr_gnt;
    assign ram_addr = wr_gnt ? wr_addr : rd_addr;
    assign ram_din  = wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_RD;
            inflight   <= 1'b0;
        end else begin
            // ram_dout after a write grant is write-through data and must not be pushed.
            inflight <= rd_gnt;
            if (wr_gnt)      last_grant <= GRANT_WR;
            else if (rd_gnt) last_grant <= GRANT_RD;
        end
    end

    spram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (ram_dout),
        .out_valid (rsp_valid),
        .out_ready (rsp_ready),
        .out_data  (rsp_data),
        .count     (occ)
    );

endmodule
